// File: rtl/iob_gpio_debounce_pkg.sv
// iob_gpio_debounce shared definitions: default widths and the
// software register field offsets consumed by the swreg generator.
package iob_gpio_debounce_pkg;

   localparam int GPIO_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   // Byte offsets of the software-visible fields.
   localparam logic [7:0] DEBOUNCE_LEN_ADDR = 8'h00;
   localparam logic [7:0] RISE_MASK_ADDR    = 8'h04;
   localparam logic [7:0] FALL_MASK_ADDR    = 8'h08;
   localparam logic [7:0] EVT_RISE_ADDR     = 8'h0C;
   localparam logic [7:0] EVT_FALL_ADDR     = 8'h10;
   localparam logic [7:0] EVT_CLR_ADDR      = 8'h14;

endpackage

// File: rtl/iob_gpio_debounce_bit.sv
// Single debounce lane: 2-flop synchroniser, stable-time counter,
// stable level and sticky rise/fall flags.
// Ports: clk, rst (sync, active high), pad_in, debounce_len, evt_clr
//        -> gpio_input (stable level), evt_rise, evt_fall.
module iob_gpio_debounce_bit
   import iob_gpio_debounce_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pad_in,
   input  logic [CNT_W-1:0] debounce_len,
   input  logic             evt_clr,
   output logic             gpio_input,
   output logic             evt_rise,
   output logic             evt_fall
);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             st_q, st_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] le_m1;

   always_comb begin
      // A length of 0 behaves like 1, so the terminal count is 0.
      le_m1  = (debounce_len == '0) ? '0 : debounce_len - CNT_W'(1);
      s1_d   = pad_in;
      s2_d   = s1_q;
      st_d   = st_q;
      cnt_d  = '0;
      // Clear first; a same-cycle set below overrides it.
      rise_d = rise_q & ~evt_clr;
      fall_d = fall_q & ~evt_clr;
      if (s2_q != st_q) begin
         // >= lets a shortened length commit on the next edge.
         if (cnt_q >= le_m1) begin
            st_d = s2_q;
            if (s2_q) rise_d = 1'b1;
            else      fall_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         st_q   <= 1'b0;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign gpio_input = st_q;
   assign evt_rise   = rise_q;
   assign evt_fall   = fall_q;

endmodule

// File: rtl/iob_gpio_debounce.sv
// GPIO input conditioning: per-bit synchronise + debounce, sticky
// edge events and a maskable interrupt.
// Ports: clk, rst, pad_in, debounce_len, rise_mask, fall_mask, evt_clr
//        -> gpio_input, evt_rise, evt_fall, irq.
module iob_gpio_debounce
   import iob_gpio_debounce_pkg::*;
#(
   parameter int GPIO_W = GPIO_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] pad_in,
   input  logic [CNT_W-1:0]  debounce_len,
   input  logic [GPIO_W-1:0] rise_mask,
   input  logic [GPIO_W-1:0] fall_mask,
   input  logic [GPIO_W-1:0] evt_clr,
   output logic [GPIO_W-1:0] gpio_input,
   output logic [GPIO_W-1:0] evt_rise,
   output logic [GPIO_W-1:0] evt_fall,
   output logic              irq
);

   for (genvar i = 0; i < GPIO_W; i++) begin : g_lane
      iob_gpio_debounce_bit #(
         .CNT_W(CNT_W)
      ) u_bit (
         .clk         (clk),
         .rst         (rst),
         .pad_in      (pad_in[i]),
         .debounce_len(debounce_len),
         .evt_clr     (evt_clr[i]),
         .gpio_input  (gpio_input[i]),
         .evt_rise    (evt_rise[i]),
         .evt_fall    (evt_fall[i])
      );
   end

   // Combinational from registered flags so mask writes act at once.
   assign irq = |((evt_rise & rise_mask) | (evt_fall & fall_mask));

endmodule
